// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read-port arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// The FSM encodings are plain localparams so that older flows can consume them.
package axi_rd_arb_pkg;
    typedef logic [3:0] req_idx_t;
    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0010;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;

    localparam state_t IDLE = 2'd0;
    localparam state_t ADDR = 2'd1;
    localparam state_t DATA = 2'd2;
endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin pick: first set valid bit at or above ptr_i, wrapping modulo NR_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arb_pick #(
    parameter int NR_REQ = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NR_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NR_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            int c;
            c = (int'(ptr_i) + i) % NR_REQ;
            if (!any_o && valid_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IDX_W'(c);
            end
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin share of one AXI4 read port among NR_REQ requesters, one burst at a time.
// Latency: grant combinational in IDLE, ARVALID the next cycle, R beats pass through with zero latency.
// Backpressure: the owner's rsp_ready_i drives RREADY; other requesters wait. AXI_RD_ARB_BEAT_CHECK_EN adds beat/ID checking.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int NR_REQ = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NR_REQ-1:0]        req_valid_i,
    output logic [NR_REQ-1:0]        req_ready_o,
    input  logic [NR_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NR_REQ*8-1:0]      req_len_i,
    input  logic [NR_REQ*3-1:0]      req_size_i,
    output logic [NR_REQ-1:0]        rsp_valid_o,
    input  logic [NR_REQ-1:0]        rsp_ready_i,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic [1:0]               rsp_resp_o,
    output logic                     rsp_last_o,
    output logic                     err_o,
    output logic [ID_W-1:0]          io_axi_arid,
    output logic [ADDR_W-1:0]        io_axi_araddr,
    output logic [7:0]               io_axi_arlen,
    output logic [2:0]               io_axi_arsize,
    output logic [1:0]               io_axi_arburst,
    output logic [3:0]               io_axi_arcache,
    output logic [2:0]               io_axi_arprot,
    output logic [3:0]               io_axi_arqos,
    output logic [3:0]               io_axi_arregion,
    output logic                     io_axi_arlock,
    output logic [3:0]               io_axi_aruser,
    output logic                     io_axi_arvalid,
    input  logic                     io_axi_arready,
    input  logic [ID_W-1:0]          io_axi_rid,
    input  logic [DATA_W-1:0]        io_axi_rdata,
    input  logic [1:0]               io_axi_rresp,
    input  logic                     io_axi_rlast,
    input  logic                     io_axi_rvalid,
    output logic                     io_axi_rready
);
    localparam int IDX_W = $clog2(NR_REQ);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    len_t              len_q, len_d;
    size_t             size_q, size_d;

    logic [ADDR_W-1:0] addr_arr [NR_REQ];
    len_t              len_arr  [NR_REQ];
    size_t             size_arr [NR_REQ];

    for (genvar k = 0; k < NR_REQ; k++) begin : g_slice
        assign addr_arr[k] = req_addr_i[k*ADDR_W +: ADDR_W];
        assign len_arr[k]  = req_len_i[k*8 +: 8];
        assign size_arr[k] = req_size_i[k*3 +: 3];
    end

    logic [NR_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    rr_arb_pick #(
        .NR_REQ (NR_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (rr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    logic             data_phase;
    logic             beat_acc;
    logic [IDX_W-1:0] rr_next;

    assign data_phase = (state_q == DATA);
    assign io_axi_rready = data_phase & rsp_ready_i[idx_q];
    assign beat_acc   = data_phase & io_axi_rvalid & io_axi_rready;
    assign rr_next    = (idx_q == IDX_W'(NR_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = ADDR;
                    idx_d   = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    len_d   = len_arr[pick_idx];
                    size_d  = size_arr[pick_idx];
                end
            end
            ADDR: begin
                if (io_axi_arready) state_d = DATA;
            end
            DATA: begin
                // Only RLAST ends ownership, whatever the beat count says.
                if (beat_acc && io_axi_rlast) begin
                    state_d = IDLE;
                    rr_d    = rr_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
        end
    end

    assign req_ready_o = (state_q == IDLE) ? pick_gnt : '0;

    always_comb begin
        rsp_valid_o = '0;
        if (data_phase) rsp_valid_o[idx_q] = io_axi_rvalid;
    end

    assign rsp_data_o = data_phase ? io_axi_rdata : '0;
    assign rsp_last_o = data_phase & io_axi_rlast;

    assign io_axi_arvalid  = (state_q == ADDR);
    assign io_axi_arid     = ID_W'(idx_q);
    assign io_axi_araddr   = addr_q;
    assign io_axi_arlen    = len_q;
    assign io_axi_arsize   = size_q;
    assign io_axi_arburst  = BURST_INCR;
    assign io_axi_arcache  = CACHE_DEFAULT;
    assign io_axi_arprot   = '0;
    assign io_axi_arqos    = '0;
    assign io_axi_arregion = '0;
    assign io_axi_arlock   = 1'b0;
    assign io_axi_aruser   = '0;

`ifdef AXI_RD_ARB_BEAT_CHECK_EN
    logic [8:0] cnt_q, cnt_d;
    logic       len_err, rid_err;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ADDR && io_axi_arready) cnt_d = '0;
        else if (beat_acc && cnt_q != 9'h1FF) cnt_d = cnt_q + 9'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign len_err = data_phase & io_axi_rvalid &
                     (io_axi_rlast ? (cnt_q != {1'b0, len_q}) : (cnt_q == {1'b0, len_q}));
    assign rid_err = (io_axi_rid != ID_W'(idx_q));
    assign err_o      = beat_acc & (len_err | rid_err);
    assign rsp_resp_o = !data_phase ? 2'b00 : (len_err ? RESP_SLVERR : io_axi_rresp);
`else
    logic unused_rid;
    assign unused_rid = ^io_axi_rid;
    assign err_o      = 1'b0;
    assign rsp_resp_o = data_phase ? io_axi_rresp : 2'b00;
`endif
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter against a transaction-level reference model.
// Latency and routing are predicted per cycle; a mid-burst reset is exercised once.
module tb_axi_rd_arbiter;
    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 4;
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
    localparam bit BEAT_CHK = 1'b1;
`else
    localparam bit BEAT_CHK = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_valid_i, req_ready_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N*8-1:0]  req_len_i;
    logic [N*3-1:0]  req_size_i;
    logic [N-1:0]    rsp_valid_o, rsp_ready_i;
    logic [DW-1:0]   rsp_data_o;
    logic [1:0]      rsp_resp_o;
    logic            rsp_last_o, err_o;
    logic [IW-1:0]   io_axi_arid;
    logic [AW-1:0]   io_axi_araddr;
    logic [7:0]      io_axi_arlen;
    logic [2:0]      io_axi_arsize;
    logic [1:0]      io_axi_arburst;
    logic [3:0]      io_axi_arcache;
    logic [2:0]      io_axi_arprot;
    logic [3:0]      io_axi_arqos, io_axi_arregion, io_axi_aruser;
    logic            io_axi_arlock, io_axi_arvalid, io_axi_arready;
    logic [IW-1:0]   io_axi_rid;
    logic [DW-1:0]   io_axi_rdata;
    logic [1:0]      io_axi_rresp;
    logic            io_axi_rlast, io_axi_rvalid, io_axi_rready;

    always #5 clk_i = ~clk_i;

    axi_rd_arbiter #(.NR_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_size_i(req_size_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_resp_o(rsp_resp_o), .rsp_last_o(rsp_last_o),
        .err_o(err_o),
        .io_axi_arid(io_axi_arid), .io_axi_araddr(io_axi_araddr), .io_axi_arlen(io_axi_arlen),
        .io_axi_arsize(io_axi_arsize), .io_axi_arburst(io_axi_arburst),
        .io_axi_arcache(io_axi_arcache), .io_axi_arprot(io_axi_arprot),
        .io_axi_arqos(io_axi_arqos), .io_axi_arregion(io_axi_arregion),
        .io_axi_arlock(io_axi_arlock), .io_axi_aruser(io_axi_aruser),
        .io_axi_arvalid(io_axi_arvalid), .io_axi_arready(io_axi_arready),
        .io_axi_rid(io_axi_rid), .io_axi_rdata(io_axi_rdata), .io_axi_rresp(io_axi_rresp),
        .io_axi_rlast(io_axi_rlast), .io_axi_rvalid(io_axi_rvalid), .io_axi_rready(io_axi_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester side: one pending burst per requester, held until granted.
    bit          pend   [N];
    logic [63:0] p_addr [N];
    logic [7:0]  p_len  [N];
    logic [2:0]  p_size [N];

    // Port-level model: FREE (grant possible), AR (address offered), DT (beats flowing).
    localparam int P_FREE = 0, P_AR = 1, P_DT = 2;
    int          phase, owner, rr, beat;
    logic [63:0] b_addr;
    logic [7:0]  b_len;
    logic [2:0]  b_size;
    int          gcnt [N];

    // Slave side: a presented beat is held until accepted.
    bit          r_hold;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [IW-1:0] r_id;

    task automatic new_req(input int k);
        pend[k]   = 1'b1;
        p_addr[k] = {$urandom, $urandom};
        p_len[k]  = 8'($urandom_range(0, 3));
        p_size[k] = 3'($urandom_range(0, 3));
    endtask

    task automatic drive_all();
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]            = pend[k];
            req_addr_i[k*AW +: AW]    = p_addr[k];
            req_len_i[k*8 +: 8]       = p_len[k];
            req_size_i[k*3 +: 3]      = p_size[k];
        end
        io_axi_rvalid = r_hold;
        io_axi_rdata  = r_data;
        io_axi_rresp  = r_resp;
        io_axi_rlast  = r_last;
        io_axi_rid    = r_id;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_req_ready"}, 64'(req_ready_o), 64'd0);
        check_eq({pfx, "_arvalid"},   64'(io_axi_arvalid), 64'd0);
        check_eq({pfx, "_rready"},    64'(io_axi_rready), 64'd0);
        check_eq({pfx, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        check_eq({pfx, "_rsp_data"},  64'(rsp_data_o), 64'd0);
        check_eq({pfx, "_rsp_resp"},  64'(rsp_resp_o), 64'd0);
        check_eq({pfx, "_rsp_last"},  64'(rsp_last_o), 64'd0);
        check_eq({pfx, "_err"},       64'(err_o), 64'd0);
        check_eq({pfx, "_araddr"},    64'(io_axi_araddr), 64'd0);
        check_eq({pfx, "_arlen"},     64'(io_axi_arlen), 64'd0);
        check_eq({pfx, "_arid"},      64'(io_axi_arid), 64'd0);
        check_eq({pfx, "_arburst"},   64'(io_axi_arburst), 64'd1);
        check_eq({pfx, "_arcache"},   64'(io_axi_arcache), 64'd2);
        check_eq({pfx, "_arconst0"},  64'({io_axi_arprot, io_axi_arqos, io_axi_arregion,
                                          io_axi_arlock, io_axi_aruser}), 64'd0);
    endtask

    initial begin
        int          exp_g;
        logic [N-1:0] exp_gnt, exp_rv;
        bit          acc, len_err, rid_err, did_rst, force_both;
        int          c;

        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0; p_addr[k] = '0; p_len[k] = '0; p_size[k] = '0; gcnt[k] = 0;
        end
        r_hold = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0; r_id = '0;
        rsp_ready_i = '0; io_axi_arready = 1'b0;
        req_valid_i = '0; req_addr_i = '0; req_len_i = '0; req_size_i = '0;
        drive_all();
        rst_ni = 1'b0;
        phase = P_FREE; owner = 0; rr = 0; beat = 0;
        b_addr = '0; b_len = '0; b_size = '0;
        did_rst = 1'b0; force_both = 1'b0;

        repeat (3) @(negedge clk_i);
        check_reset_outputs("rst");
        rst_ni = 1'b1;

        // First burst mirrors the bring-up case: requester 0, 0x8000_0000, len 3, size 3.
        pend[0] = 1'b1; p_addr[0] = 64'h8000_0000; p_len[0] = 8'd3; p_size[0] = 3'd3;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk_i);

            if (!did_rst && cyc > 1500 && phase == P_DT) begin
                did_rst = 1'b1;
                for (int k = 0; k < N; k++) pend[k] = 1'b0;
                r_hold = 1'b0; r_data = {$urandom, $urandom}; r_last = 1'b1;
                drive_all();
                rst_ni = 1'b0;
                #1 check_reset_outputs("midrst");
                @(negedge clk_i);
                check_reset_outputs("midrst_hold");
                rst_ni = 1'b1;
                phase = P_FREE; rr = 0; r_last = 1'b0;
                new_req(0); new_req(1);
                force_both = 1'b1;
                continue;
            end

            if (cyc > 0 && !force_both) begin
                for (int k = 0; k < N; k++) begin
                    if (!pend[k] && $urandom_range(0, 3) == 0) new_req(k);
                    else if (pend[k] && $urandom_range(0, 31) == 0) pend[k] = 1'b0;
                end
            end
            rsp_ready_i    = N'($urandom_range(0, (1 << N) - 1)) | N'($urandom_range(0, (1 << N) - 1));
            io_axi_arready = (cyc == 0) || ($urandom_range(0, 2) == 0);
            if (phase == P_DT) begin
                if (!r_hold && ($urandom_range(0, 1) == 0 || cyc < 20)) begin
                    r_hold = 1'b1;
                    r_data = {$urandom, $urandom};
                    r_resp = 2'($urandom_range(0, 3));
                    if (beat == int'(b_len)) r_last = ($urandom_range(0, 15) != 0);
                    else                     r_last = ($urandom_range(0, 15) == 0);
                    r_id = ($urandom_range(0, 7) == 0) ? IW'($urandom) : IW'(owner);
                end
            end else begin
                r_hold = 1'b0;
            end
            drive_all();
            #1;

            exp_g = -1;
            if (phase == P_FREE) begin
                for (int j = 0; j < N; j++) begin
                    c = (rr + j) % N;
                    if (exp_g < 0 && pend[c]) exp_g = c;
                end
            end
            exp_gnt = (exp_g >= 0) ? (N'(1) << exp_g) : '0;
            check_eq("req_ready", 64'(req_ready_o), 64'(exp_gnt));
            if (force_both) begin
                check_eq("post_rst_gnt0", 64'(req_ready_o), 64'd1);
                force_both = 1'b0;
            end

            check_eq("arvalid", 64'(io_axi_arvalid), 64'(phase == P_AR));
            if (phase == P_AR) begin
                check_eq("araddr", 64'(io_axi_araddr), b_addr);
                check_eq("arlen",  64'(io_axi_arlen),  64'(b_len));
                check_eq("arsize", 64'(io_axi_arsize), 64'(b_size));
                check_eq("arid",   64'(io_axi_arid),   64'(owner));
                check_eq("arburst", 64'(io_axi_arburst), 64'd1);
            end

            check_eq("rready", 64'(io_axi_rready), 64'(phase == P_DT && rsp_ready_i[owner]));
            exp_rv = (phase == P_DT && r_hold) ? (N'(1) << owner) : '0;
            check_eq("rsp_valid", 64'(rsp_valid_o), 64'(exp_rv));

            acc     = (phase == P_DT) && r_hold && rsp_ready_i[owner];
            len_err = BEAT_CHK && (phase == P_DT) && r_hold &&
                      (r_last ? (beat != int'(b_len)) : (beat == int'(b_len)));
            rid_err = BEAT_CHK && (r_id != IW'(owner));
            if (phase == P_DT && r_hold) begin
                check_eq("rsp_data", rsp_data_o, r_data);
                check_eq("rsp_last", 64'(rsp_last_o), 64'(r_last));
                check_eq("rsp_resp", 64'(rsp_resp_o), len_err ? 64'd2 : 64'(r_resp));
            end
            check_eq("err", 64'(err_o), 64'(acc && (len_err || rid_err)));

            case (phase)
                P_FREE: if (exp_g >= 0) begin
                    phase  = P_AR;
                    owner  = exp_g;
                    b_addr = p_addr[exp_g];
                    b_len  = p_len[exp_g];
                    b_size = p_size[exp_g];
                    pend[exp_g] = 1'b0;
                    gcnt[exp_g]++;
                end
                P_AR: if (io_axi_arready) begin
                    phase = P_DT;
                    beat  = 0;
                end
                default: if (acc) begin
                    beat++;
                    r_hold = 1'b0;
                    if (r_last) begin
                        phase = P_FREE;
                        rr    = (owner + 1) % N;
                    end
                end
            endcase
        end

        check_eq("mid_reset_reached", 64'(did_rst), 64'd1);
        for (int k = 0; k < N; k++) check_eq("not_starved", 64'(gcnt[k] > 100), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Round-robin arbiter sharing one flattened AXI4 read master port (AR/R, io_axi_* style) between NR_REQ internal requesters, e.g. instruction fetch, PTW, debug, next to the core's top-level AXI flattening.
- One burst outstanding at a time; the port is locked to the granted requester until RLAST.
- ARID carries the requester index.

Parameters:
- NR_REQ, 2, number of requesters (2..16)
- ADDR_W, 64, address width
- DATA_W, 64, data width
- ID_W, 4, AXI ID width; must satisfy $clog2(NR_REQ) <= ID_W

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NR_REQ  request pending, per requester
- req_ready_o  out  NR_REQ  request accepted (one-hot pulse)
- req_addr_i  in  NR_REQ*ADDR_W  burst start address, requester k at slice k
- req_len_i  in  NR_REQ*8  AXI len (beats-1)
- req_size_i  in  NR_REQ*3  AXI size
- rsp_valid_o  out  NR_REQ  beat valid to owning requester
- rsp_ready_i  in  NR_REQ  requester accepts beat
- rsp_data_o  out  DATA_W  beat data, broadcast to all requesters
- rsp_resp_o  out  2  beat response
- rsp_last_o  out  1  last beat
- err_o  out  1  burst length violation pulse
- io_axi_arid  out  ID_W  equals granted index, zero-extended
- io_axi_araddr  out  ADDR_W
- io_axi_arlen  out  8
- io_axi_arsize  out  3
- io_axi_arburst  out  2  constant INCR (2'b01)
- io_axi_arcache  out  4  constant 4'b0010
- io_axi_arprot, io_axi_arqos, io_axi_arregion, io_axi_arlock, io_axi_aruser  out  3/4/4/1/4  constant 0
- io_axi_arvalid  out  1
- io_axi_arready  in  1
- io_axi_rid  in  ID_W
- io_axi_rdata  in  DATA_W
- io_axi_rresp  in  2
- io_axi_rlast  in  1
- io_axi_rvalid  in  1
- io_axi_rready  out  1

Behaviour:
- Reset: state IDLE, rr pointer 0, latched addr/len/size/idx 0. All outputs 0 except the constant AR fields.
- FSM IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If any req_valid_i is set, grant the first set bit searching from the rr pointer upward, wrapping modulo NR_REQ.
  - Assert req_ready_o[g] combinationally in that same cycle; latch addr, len, size and g; go to ADDR.
  - Requesters must hold req_* stable while valid. A requester may drop valid before grant with no effect.
- ADDR:
  - io_axi_arvalid=1 and AR fields driven from registers, so arvalid rises the cycle after the grant.
  - Fields stay stable until io_axi_arready.
  - arvalid & arready -> DATA.
- DATA:
  - io_axi_rready = rsp_ready_i[idx].
  - rsp_valid_o[idx] = io_axi_rvalid; all other rsp_valid_o bits are 0.
  - rsp_data_o, rsp_resp_o and rsp_last_o pass through combinationally (zero latency).
  - Routing always uses the latched idx; io_axi_rid is ignored for routing.
  - A beat with rvalid & rready & rlast -> IDLE and rr pointer <= (idx+1) mod NR_REQ.
- No new grant is issued before the return to IDLE. Minimum turnaround is 1 idle cycle between bursts.
- Backpressure from the owning requester stalls the port. No timeout.
- A requester that is granted and then deasserts req_valid_i still owns the burst through completion.
- Asynchronous reset mid-burst aborts everything. External slave recovery is out of scope.

Optional Feature:
- Macro AXI_RD_ARB_BEAT_CHECK_EN.
- Defined:
  - 9-bit beat counter, cleared on entry to DATA and incremented per accepted beat.
  - A beat with rlast where counter != len, or a beat without rlast where counter == len, is an error.
  - On an error beat: err_o pulses 1 cycle and rsp_resp_o is forced to 2'b10 (SLVERR).
  - Early rlast still returns to IDLE. Missing rlast keeps DATA until rlast arrives.
  - An accepted beat with io_axi_rid != idx also pulses err_o, with data passed unmodified.
- Undefined: no counter and no rid compare; err_o tied 0.

Decomposition:
- Package axi_rd_arb_pkg holds:
  - typedefs req_idx_t, len_t, size_t
  - constants BURST_INCR=2'b01, CACHE_DEFAULT=4'b0010, RESP_SLVERR=2'b10
  - state enum {IDLE, ADDR, DATA}
- One sub-module, rr_arb_pick: combinational round-robin priority pick (valid vector + pointer -> one-hot grant + index). The rest of the logic is the top FSM.

Test Plan:
- Single requester 0, addr 0x8000_0000, len 3, size 3, arready immediate, 4 beats with rlast on the 4th:
  - req_ready_o=01 at T; arvalid at T+1 with arid=0, arlen=3, araddr=0x8000_0000.
  - rsp_valid_o[0] pulses 4 times; return to IDLE.
- Both requesters valid continuously, len 0 each, NR_REQ=2: grants alternate 0,1,0,1; arid alternates 0,1; no requester is starved.
- arready held low 5 cycles: arvalid stays 1 with araddr/arlen stable; no second req_ready_o pulse.
- rsp_ready_i[1]=0 for 3 cycles mid-burst of requester 1: io_axi_rready=0 for those cycles; beat count and order are preserved.
- rst_ni asserted during DATA: next cycle all outputs are 0 and the FSM is in IDLE; after release, requester 0 is granted first.
- With AXI_RD_ARB_BEAT_CHECK_EN, len 3 and rlast on beat 2: err_o=1 on that beat, rsp_resp_o=2'b10, FSM returns to IDLE.
